// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 1010 serial pattern detector.
// State encoding is fixed and exported on the debug port.
package seq_det_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S0   = 2'd0;
  localparam state_t S1   = 2'd1;
  localparam state_t S10  = 2'd2;
  localparam state_t S101 = 2'd3;

  localparam int PAT_W = 4;

endpackage

// File: rtl/seq_det_1010_nonoverlap.sv
// Non-overlapping 1010 detector: one bit per clock, registered
// one-cycle match flag, raw state register exported for debug.
module seq_det_1010_nonoverlap
  import seq_det_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       In,
  output logic       OP,
  output logic [1:0] state
);

  state_t state_q, state_d;
  logic   op_q, op_d;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // A match restarts from S0 so the trailing 10 is never reused.
  always_comb begin
    state_d = S0;
    op_d    = 1'b0;
    case (state_q)
      S0:   state_d = In ? S1 : S0;
      S1:   state_d = In ? S1 : S10;
      S10:  state_d = In ? S101 : S0;
      S101: begin
        state_d = In ? S1 : S0;
        op_d    = ~In;
      end
      default: begin
        state_d = S0;
        op_d    = 1'b0;
      end
    endcase
  end

  assign state = state_q;
  assign OP    = op_q;

endmodule

// File: tb/tb_seq_det_1010_nonoverlap.sv
// Directed bench for the 1010 detector: literal per-step checks
// plus a suffix-matching reference compared every cycle.
module tb_seq_det_1010_nonoverlap;

  logic       Clk;
  logic       Rst;
  logic       In;
  logic       OP;
  logic [1:0] state;

  int n_run  = 0;
  int n_fail = 0;

  seq_det_1010_nonoverlap dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .In    (In),
    .OP    (OP),
    .state (state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: remember recent bits since the last restart; state is
  // the length of the longest suffix that is a prefix of 1010.
  bit         pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit         hist[$];
  logic [1:0] m_state = 2'd0;
  logic       m_op    = 1'b0;

  function automatic bit suffix_is_prefix(int k);
    int n;
    n = hist.size();
    if (n < k) return 1'b0;
    for (int i = 0; i < k; i++)
      if (hist[n-k+i] != pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [1:0] prefix_len();
    for (int k = 3; k >= 1; k--)
      if (suffix_is_prefix(k)) return 2'(k);
    return 2'd0;
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hist.delete();
      m_state = 2'd0;
      m_op    = 1'b0;
    end else begin
      hist.push_back(In);
      if (hist.size() > 4) void'(hist.pop_front());
      if (suffix_is_prefix(4)) begin
        m_op = 1'b1;
        hist.delete();
        m_state = 2'd0;
      end else begin
        m_op    = 1'b0;
        m_state = prefix_len();
      end
    end
  end

  always @(negedge Clk) begin
    n_run++;
    if (state !== m_state || OP !== m_op) begin
      n_fail++;
      $display("FAIL model t=%0t state=%0d OP=%b required state=%0d OP=%b",
               $time, state, OP, m_state, m_op);
    end
  end

  task automatic chk(string name, logic [1:0] es, logic eo);
    n_run++;
    if (state !== es || OP !== eo) begin
      n_fail++;
      $display("FAIL %s t=%0t state=%0d OP=%b required state=%0d OP=%b",
               name, $time, state, OP, es, eo);
    end
  endtask

  task automatic send(string name, logic b, logic [1:0] es, logic eo);
    @(negedge Clk);
    In  = b;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    chk(name, es, eo);
  endtask

  task automatic run_vec(string name, logic [7:0] bits, int n,
                         logic [15:0] sts, logic [7:0] ops);
    for (int i = 0; i < n; i++)
      send(name, bits[n-1-i], sts[2*(n-1-i) +: 2], ops[n-1-i]);
  endtask

  initial begin
    Rst = 1'b0;
    In  = 1'b1;
    #1;
    chk("reset_t0", 2'd0, 1'b0);
    repeat (3) begin
      @(posedge Clk);
      #1;
      chk("reset_hold", 2'd0, 1'b0);
    end

    run_vec("basic", 8'b0100_1010, 8,
            {2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0},
            8'b0000_0001);

    run_vec("nonoverlap", 8'b1011_0100, 8,
            {2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0},
            8'b0000_0010);

    run_vec("break_s101", 8'b0000_1011, 4,
            {8'd0, 2'd1, 2'd2, 2'd3, 2'd1}, 8'b0000_0000);

    run_vec("back2back", 8'b1010_1010, 8,
            {2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0},
            8'b0001_0001);

    // OP is high here; an async reset must drop it immediately.
    #2;
    Rst = 1'b0;
    #1;
    chk("rst_clears_op", 2'd0, 1'b0);

    run_vec("pre_rst", 8'b0000_0101, 3,
            {10'd0, 2'd1, 2'd2, 2'd3}, 8'b0000_0000);
    #2;
    In  = 1'b1;
    Rst = 1'b0;
    #1;
    chk("midpat_rst", 2'd0, 1'b0);
    @(posedge Clk);
    #1;
    chk("midpat_hold", 2'd0, 1'b0);
    send("after_rst", 1'b0, 2'd0, 1'b0);

    run_vec("post_rst", 8'b0000_1010, 4,
            {8'd0, 2'd1, 2'd2, 2'd3, 2'd0}, 8'b0000_0001);

    @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
